fu_writeback_arbiter: RTL and testbench

Collects completed results from all functional-unit queue wrappers and serialises them onto the single physical-register-file write port and the ROB completion port. Each FU output lands in a small per-FU FIFO; a round-robin arbiter drains one result per cycle. The registered write-port outputs double as the PRN wakeup broadcast that issue queues snoop.

---
 rtl/wb_pkg.sv | 24 ++
 rtl/wb_fifo.sv | 58 +++++
 rtl/fu_writeback_arbiter.sv | 153 +++++++++++++++
 tb/tb_fu_writeback_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_pkg: writeback entry type and round-robin helper.  Rev 1.0            |
// +--------------------------------------------------------------------------+
package wb_pkg;

  localparam int WB_INST_ID_BITS = 6;
  localparam int WB_PRN_BITS     = 6;
  localparam int WB_MAX_OPERANDS = 3;
  localparam int WB_DATA_BITS    = 64;

  typedef struct packed {
    logic [WB_INST_ID_BITS-1:0]                    inst_id;
    logic [WB_MAX_OPERANDS-1:0][WB_PRN_BITS-1:0]   prn;
    logic [WB_MAX_OPERANDS-1:0][WB_DATA_BITS-1:0]  data;
    logic [WB_MAX_OPERANDS-1:0]                    data_valid;
  } wb_entry_t;

  function automatic int rr_next(input int winner, input int n);
    return (winner + 1) % n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | wb_fifo: per-FU result FIFO of wb_entry_t, power-of-two depth.  Rev 1.0  |
// +--------------------------------------------------------------------------+
module wb_fifo
  import wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int AW = $clog2(FIFO_DEPTH);

  wb_entry_t       mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst && !flush) mem[wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/fu_writeback_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fu_writeback_arbiter: round-robin drain of per-FU FIFOs onto PRF/ROB.    |
// | Optional WB_BYPASS_EN lets an idle FU skip its FIFO.  Rev 1.0            |
// +--------------------------------------------------------------------------+
module fu_writeback_arbiter
  import wb_pkg::*;
#(
  parameter int INST_ID_BITS = WB_INST_ID_BITS,
  parameter int PRN_BITS     = WB_PRN_BITS,
  parameter int MAX_OPERANDS = WB_MAX_OPERANDS,
  parameter int FU_COUNT     = 4,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    fu_out_valid      [FU_COUNT],
  input  logic [INST_ID_BITS-1:0] fu_out_inst_id    [FU_COUNT],
  input  logic [PRN_BITS-1:0]     fu_out_prn        [FU_COUNT][MAX_OPERANDS],
  input  logic [63:0]             fu_out_data       [FU_COUNT][MAX_OPERANDS],
  input  logic                    fu_out_data_valid [FU_COUNT][MAX_OPERANDS],
  output logic                    fu_ready          [FU_COUNT],
  output logic                    prf_write_enable  [MAX_OPERANDS],
  output logic [PRN_BITS-1:0]     prf_write_prn     [MAX_OPERANDS],
  output logic [63:0]             prf_write_data    [MAX_OPERANDS],
  output logic                    rob_complete_valid,
  output logic [INST_ID_BITS-1:0] rob_complete_inst_id
);

  localparam int PTR_W = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

  wb_entry_t             in_entry [FU_COUNT];
  wb_entry_t             heads    [FU_COUNT];
  wb_entry_t             sel;
  logic [FU_COUNT-1:0]   full;
  logic [FU_COUNT-1:0]   empty;
  logic [FU_COUNT-1:0]   req;
  logic [FU_COUNT-1:0]   grant_oh;
  logic [FU_COUNT-1:0]   push;
  logic [FU_COUNT-1:0]   pop;
  logic [PTR_W-1:0]      rr_ptr;
  logic [PTR_W-1:0]      grant_idx;
  logic [PTR_W-1:0]      cand;
  logic                  grant_valid;
  int                    idx;

  always_comb begin
    for (int i = 0; i < FU_COUNT; i++) begin
      in_entry[i]         = '0;
      in_entry[i].inst_id = fu_out_inst_id[i];
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        in_entry[i].prn[k]        = fu_out_prn[i][k];
        in_entry[i].data[k]       = fu_out_data[i][k];
        in_entry[i].data_valid[k] = fu_out_data_valid[i][k];
      end
    end
  end

  generate
    for (genvar i = 0; i < FU_COUNT; i++) begin : g_fu
      assign fu_ready[i] = !full[i];
`ifdef WB_BYPASS_EN
      // An empty FIFO still competes when its input is valid this cycle.
      assign req[i] = !empty[i] || fu_out_valid[i];
`else
      assign req[i] = !empty[i];
`endif
      assign grant_oh[i] = grant_valid && (grant_idx == PTR_W'(i));
      assign pop[i]      = grant_oh[i] && !empty[i];
      assign push[i]     = fu_out_valid[i] && fu_ready[i] && !(grant_oh[i] && empty[i]);

      wb_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push[i]),
        .push_data (in_entry[i]),
        .pop       (pop[i]),
        .full      (full[i]),
        .empty     (empty[i]),
        .head      (heads[i])
      );
    end
  endgenerate

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int off = 0; off < FU_COUNT; off++) begin
      idx  = (int'(rr_ptr) + off) % FU_COUNT;
      cand = PTR_W'(idx);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    sel = heads[grant_idx];
`ifdef WB_BYPASS_EN
    if (empty[grant_idx]) sel = in_entry[grant_idx];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (!flush && grant_valid) begin
      rr_ptr <= PTR_W'(rr_next(int'(grant_idx), FU_COUNT));
    end
  end

  // The registered write port doubles as the wakeup broadcast.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rob_complete_valid   <= 1'b0;
      rob_complete_inst_id <= '0;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        prf_write_enable[k] <= 1'b0;
        prf_write_prn[k]    <= '0;
        prf_write_data[k]   <= '0;
      end
    end else begin
      rob_complete_valid <= grant_valid;
      for (int k = 0; k < MAX_OPERANDS; k++) begin
        prf_write_enable[k] <= grant_valid && sel.data_valid[k];
      end
      if (grant_valid) begin
        rob_complete_inst_id <= sel.inst_id;
        for (int k = 0; k < MAX_OPERANDS; k++) begin
          prf_write_prn[k]  <= sel.prn[k];
          prf_write_data[k] <= sel.data[k];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_COUNT; i++) begin
      if (!rst) assert (!(fu_out_valid[i] && !fu_ready[i]));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fu_writeback_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fu_writeback_arbiter: scoreboard bench with queue-based FU model.     |
// +--------------------------------------------------------------------------+
module tb_fu_writeback_arbiter;

  localparam int N     = 4;
  localparam int OPS   = 3;
  localparam int DEPTH = 2;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [5:0]         id;
    logic [2:0][5:0]    prn;
    logic [2:0][63:0]   data;
    logic [2:0]         dv;
  } ent_t;

  typedef struct packed {
    ent_t e;
    int   stamp;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid [N];
  logic [5:0]  in_id    [N];
  logic [5:0]  in_prn   [N][OPS];
  logic [63:0] in_data  [N][OPS];
  logic        in_dv    [N][OPS];
  logic        ready    [N];
  logic        we       [OPS];
  logic [5:0]  wprn     [OPS];
  logic [63:0] wdata    [OPS];
  logic        rcv;
  logic [5:0]  rcid;

  fu_writeback_arbiter #(
    .INST_ID_BITS (6),
    .PRN_BITS     (6),
    .MAX_OPERANDS (OPS),
    .FU_COUNT     (N),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush                (flush),
    .fu_out_valid         (in_valid),
    .fu_out_inst_id       (in_id),
    .fu_out_prn           (in_prn),
    .fu_out_data          (in_data),
    .fu_out_data_valid    (in_dv),
    .fu_ready             (ready),
    .prf_write_enable     (we),
    .prf_write_prn        (wprn),
    .prf_write_data       (wdata),
    .rob_complete_valid   (rcv),
    .rob_complete_inst_id (rcid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdl_edge = 0;
  int   mon_edge = 0;
  int   rr       = 0;
  ent_t mq [N][$];
  exp_t exp_q [$];
  ent_t stim [N];
  logic [5:0] id_ctr = 6'd0;

  function automatic ent_t cur_ent(input int i);
    ent_t e;
    e.id = in_id[i];
    for (int k = 0; k < OPS; k++) begin
      e.prn[k]  = in_prn[i][k];
      e.data[k] = in_data[i][k];
      e.dv[k]   = in_dv[i][k];
    end
    return e;
  endfunction

  function automatic ent_t rand_ent();
    ent_t e;
    e.id = id_ctr;
    id_ctr = id_ctr + 6'd1;
    for (int k = 0; k < OPS; k++) begin
      e.prn[k]  = 6'($urandom);
      e.data[k] = {$urandom, $urandom};
    end
    e.dv = 3'($urandom);
    return e;
  endfunction

  // Reference model: per-FU queues drained one per cycle, round robin.
  always @(posedge clk) begin
    int   win;
    int   byp;
    int   j;
    bit   rdy [N];
    exp_t x;
    mdl_edge++;
    if (rst) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      rr = 0;
    end else if (flush) begin
      for (int i = 0; i < N; i++) mq[i].delete();
    end else begin
      win = -1;
      byp = -1;
      for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < DEPTH);
      for (int off = 0; off < N; off++) begin
        j = (rr + off) % N;
        if (win < 0 && (mq[j].size() > 0 || (BYP && in_valid[j]))) win = j;
      end
      if (win >= 0) begin
        if (mq[win].size() > 0) begin
          x.e = mq[win].pop_front();
        end else begin
          x.e = cur_ent(win);
          byp = win;
        end
        x.stamp = mdl_edge;
        exp_q.push_back(x);
        rr = (win + 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (in_valid[i] && rdy[i] && i != byp) mq[i].push_back(cur_ent(i));
    end
  end

  // Monitor: compares every registered output cycle against the scoreboard.
  initial begin
    exp_t x;
    bit   ok;
    forever begin
      @(posedge clk);
      mon_edge++;
      #1;
      if (rcv === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got id=%0d at edge %0d, required no output", rcid, mon_edge);
        end else begin
          x  = exp_q.pop_front();
          ok = (rcid === x.e.id) && (x.stamp == mon_edge);
          for (int k = 0; k < OPS; k++) begin
            ok = ok && (we[k] === x.e.dv[k]);
            if (x.e.dv[k]) ok = ok && (wprn[k] === x.e.prn[k]) && (wdata[k] === x.e.data[k]);
          end
          if (!ok) begin
            n_fail++;
            $display("FAIL writeback: got id=%0d edge=%0d we=%b%b%b prn0=%0d data0=%h, required id=%0d edge=%0d we=%b prn0=%0d data0=%h",
                     rcid, mon_edge, we[2], we[1], we[0], wprn[0], wdata[0],
                     x.e.id, x.stamp, x.e.dv, x.e.prn[0], x.e.data[0]);
          end
        end
      end else begin
        n_checks++;
        ok = (rcv === 1'b0) && (we[0] === 1'b0) && (we[1] === 1'b0) && (we[2] === 1'b0);
        if (exp_q.size() > 0 && exp_q[0].stamp <= mon_edge) begin
          x  = exp_q.pop_front();
          ok = 1'b0;
          $display("FAIL missing_output: got rcv=%b at edge %0d, required id=%0d", rcv, mon_edge, x.e.id);
        end else if (!ok) begin
          $display("FAIL idle_outputs: got rcv=%b we=%b%b%b, required all 0", rcv, we[2], we[1], we[0]);
        end
        if (!ok) n_fail++;
      end
    end
  end

  task automatic cyc(input logic [N-1:0] want, input bit fl, input bit rs);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (ready[i] !== (mq[i].size() < DEPTH)) begin
        n_fail++;
        $display("FAIL fu_ready[%0d]: got %b, required %b", i, ready[i], (mq[i].size() < DEPTH));
      end
    end
    rst   = rs;
    flush = fl;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = want[i] && (mq[i].size() < DEPTH);
      in_id[i]    = stim[i].id;
      for (int k = 0; k < OPS; k++) begin
        in_prn[i][k]  = stim[i].prn[k];
        in_data[i][k] = stim[i].data[k];
        in_dv[i][k]   = stim[i].dv[k];
      end
    end
  endtask

  task automatic zero_check(input string tag);
    bit ok;
    @(posedge clk);
    #2;
    ok = (rcv === 1'b0) && (rcid === 6'd0);
    for (int k = 0; k < OPS; k++)
      ok = ok && (we[k] === 1'b0) && (wprn[k] === 6'd0) && (wdata[k] === 64'd0);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got rcv=%b id=%0d we0=%b prn0=%0d data0=%h, required all 0",
               tag, rcv, rcid, we[0], wprn[0], wdata[0]);
    end
  endtask

  task automatic new_stim();
    for (int i = 0; i < N; i++) stim[i] = rand_ent();
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i] = 1'b0;
      stim[i]     = '0;
    end
    repeat (2) @(posedge clk);
    cyc('0, 1'b0, 1'b1);
    zero_check("reset_outputs");

    // Single result on FU2
    repeat (8) cyc('0, 1'b0, 1'b0);
    new_stim();
    stim[2].id      = 6'd5;
    stim[2].prn[0]  = 6'd12;
    stim[2].data[0] = 64'hDEAD;
    stim[2].dv      = 3'b001;
    cyc(4'b0100, 1'b0, 1'b0);
    repeat (4) cyc('0, 1'b0, 1'b0);

    // All four FUs at once after a fresh reset
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b0);
    new_stim();
    cyc(4'b1111, 1'b0, 1'b0);
    repeat (6) cyc('0, 1'b0, 1'b0);

    // FU0 and FU1 streaming
    for (int c = 0; c < 12; c++) begin
      new_stim();
      cyc(4'b0011, 1'b0, 1'b0);
    end
    repeat (6) cyc('0, 1'b0, 1'b0);

    // No-writeback result
    new_stim();
    stim[1].id = 6'd9;
    stim[1].dv = 3'b000;
    cyc(4'b0010, 1'b0, 1'b0);
    repeat (3) cyc('0, 1'b0, 1'b0);

    // Fill three FIFOs then flush
    for (int c = 0; c < 3; c++) begin
      new_stim();
      cyc(4'b0111, 1'b0, 1'b0);
    end
    new_stim();
    cyc(4'b0111, 1'b1, 1'b0);
    repeat (4) cyc('0, 1'b0, 1'b0);

    // Reset mid-stream, then all request
    for (int c = 0; c < 3; c++) begin
      new_stim();
      cyc(4'b1111, 1'b0, 1'b0);
    end
    new_stim();
    cyc(4'b1111, 1'b0, 1'b1);
    zero_check("midstream_reset");
    new_stim();
    cyc(4'b1111, 1'b0, 1'b0);
    repeat (6) cyc('0, 1'b0, 1'b0);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 400; c++) begin
      new_stim();
      cyc(4'($urandom) & 4'($urandom | $urandom),
          ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
    end
    repeat (10) cyc('0, 1'b0, 1'b0);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results never observed, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
